// File: rtl/aes_ctr_xcrypt.sv
// aes_ctr_xcrypt: AES-CTR XOR stage that prefetches {nonce, counter} pads into a small FIFO and XORs them onto data beats.
module aes_ctr_xcrypt #(
  parameter int          PAD_FIFO_DEPTH = 2,
  parameter logic [31:0] INIT_COUNTER   = 32'd1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [95:0]  cmd_nonce,
  input  logic         cmd_val,
  output logic         cmd_rdy,
  input  logic [127:0] in_data,
  input  logic         in_last,
  input  logic         in_val,
  output logic         in_rdy,
  output logic [127:0] out_data,
  output logic         out_last,
  output logic         out_val,
  input  logic         out_rdy,
  output logic [95:0]  aes_nonce,
  output logic [31:0]  aes_counter,
  output logic         aes_req_val,
  input  logic         aes_req_rdy,
  input  logic [127:0] aes_pad,
  input  logic         aes_pad_val,
  output logic         aes_pad_rdy,
  output logic         busy,
  output logic         ctr_wrap
);
  localparam int AW = PAD_FIFO_DEPTH > 1 ? $clog2(PAD_FIFO_DEPTH) : 1;
  localparam int CW = $clog2(PAD_FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t        state_q;
  logic [127:0]  mem_q [PAD_FIFO_DEPTH];
  logic [AW-1:0] rd_q, wr_q, rd_nxt, wr_nxt;
  logic [CW-1:0] cnt_q;
  logic [31:0]   ctr_q;
  logic [95:0]   nonce_q;
  logic          pend_q, wrap_q, ne, req_hs, pad_hs, xfer, flush, push;
  assign ne          = (state_q == RUN) && (cnt_q != '0);
  assign cmd_rdy     = state_q == IDLE;
  assign in_rdy      = out_rdy & ne;
  assign out_val     = in_val & ne;
  assign out_data    = ne ? in_data ^ mem_q[rd_q] : '0;
  assign out_last    = in_last;
  // single outstanding request; credit = free FIFO slots not already promised
  assign aes_req_val = (state_q == RUN) && !pend_q && (cnt_q < CW'(PAD_FIFO_DEPTH));
  assign aes_nonce   = nonce_q;
  assign aes_counter = aes_req_val ? ctr_q : '0;
  assign aes_pad_rdy = pend_q;
  assign busy        = state_q != IDLE;
  assign ctr_wrap    = wrap_q;
  assign req_hs      = aes_req_val & aes_req_rdy;
  assign pad_hs      = aes_pad_val & aes_pad_rdy;
  assign xfer        = in_val & in_rdy;
  assign flush       = xfer & in_last;
  assign push        = pad_hs & (state_q == RUN) & ~flush;
  assign rd_nxt      = (rd_q == AW'(PAD_FIFO_DEPTH - 1)) ? '0 : rd_q + AW'(1);
  assign wr_nxt      = (wr_q == AW'(PAD_FIFO_DEPTH - 1)) ? '0 : wr_q + AW'(1);
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= aes_pad;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      pend_q  <= 1'b0;
      ctr_q   <= INIT_COUNTER;
      nonce_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      if (push) wr_q <= wr_nxt;
      if (xfer) rd_q <= rd_nxt;
      cnt_q <= cnt_q + CW'(push) - CW'(xfer);
      if (req_hs) begin
        pend_q <= 1'b1;
        ctr_q  <= ctr_q + 32'd1;
        if (ctr_q == '1) wrap_q <= 1'b1;
      end
      if (pad_hs) pend_q <= 1'b0;
      case (state_q)
        IDLE: if (cmd_val) begin
          nonce_q <= cmd_nonce;
          ctr_q   <= INIT_COUNTER;
          wrap_q  <= 1'b0;
          state_q <= RUN;
        end
        RUN: if (flush) begin
          state_q <= DRAIN;
          cnt_q   <= '0;
          rd_q    <= '0;
          wr_q    <= '0;
        end
        DRAIN: if (!pend_q || pad_hs) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_ctr_xcrypt.sv
// tb_aes_ctr_xcrypt: directed bench with a pad-generator model; a second instance covers counter wrap.
module tb_aes_ctr_xcrypt;
  logic clk = 1'b0, rst = 1'b1;
  logic [95:0] cmd_nonce, aes_nonce, w_cmd_nonce, w_aes_nonce;
  logic cmd_val, cmd_rdy, in_last, in_val, in_rdy, out_last, out_val, out_rdy;
  logic aes_req_val, aes_req_rdy, aes_pad_val, aes_pad_rdy, busy, ctr_wrap;
  logic w_cmd_val, w_cmd_rdy, w_in_last, w_in_val, w_in_rdy, w_out_last, w_out_val, w_out_rdy;
  logic w_req_val, w_pad_val, w_pad_rdy, w_busy, w_ctr_wrap;
  logic [127:0] in_data, out_data, aes_pad, w_in_data, w_out_data, w_pad;
  logic [31:0] aes_counter, w_counter;
  int checks = 0, failures = 0;
  int gen_lat = 1, gen_cnt = 0, issued = 0, xfers = 0, peak = 0;
  logic gen_busy = 1'b0;
  logic [31:0] gen_ctr;
  logic [31:0] req_log[$], w_log[$];
  logic [95:0] non_log[$];
  logic [127:0] obs_d[$], w_obs[$];
  logic obs_l[$];
  logic [127:0] d4 [4];

  aes_ctr_xcrypt dut (
    .clk(clk), .rst(rst), .cmd_nonce(cmd_nonce), .cmd_val(cmd_val), .cmd_rdy(cmd_rdy),
    .in_data(in_data), .in_last(in_last), .in_val(in_val), .in_rdy(in_rdy),
    .out_data(out_data), .out_last(out_last), .out_val(out_val), .out_rdy(out_rdy),
    .aes_nonce(aes_nonce), .aes_counter(aes_counter), .aes_req_val(aes_req_val), .aes_req_rdy(aes_req_rdy),
    .aes_pad(aes_pad), .aes_pad_val(aes_pad_val), .aes_pad_rdy(aes_pad_rdy), .busy(busy), .ctr_wrap(ctr_wrap));

  aes_ctr_xcrypt #(.PAD_FIFO_DEPTH(2), .INIT_COUNTER(32'hFFFFFFFF)) wdut (
    .clk(clk), .rst(rst), .cmd_nonce(w_cmd_nonce), .cmd_val(w_cmd_val), .cmd_rdy(w_cmd_rdy),
    .in_data(w_in_data), .in_last(w_in_last), .in_val(w_in_val), .in_rdy(w_in_rdy),
    .out_data(w_out_data), .out_last(w_out_last), .out_val(w_out_val), .out_rdy(w_out_rdy),
    .aes_nonce(w_aes_nonce), .aes_counter(w_counter), .aes_req_val(w_req_val), .aes_req_rdy(1'b1),
    .aes_pad(w_pad), .aes_pad_val(w_pad_val), .aes_pad_rdy(w_pad_rdy), .busy(w_busy), .ctr_wrap(w_ctr_wrap));

  always #5 clk = ~clk;

  function automatic logic [127:0] pad_fn(input logic [31:0] c);
    return {32'hDEADBEEF, c, 32'hCAFEF00D, ~c};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // pad generator models and output monitors
  always @(posedge clk) begin
    if (rst) begin
      gen_busy = 1'b0;
      aes_pad_val <= 1'b0;
      w_pad_val <= 1'b0;
    end else begin
      if (cmd_val && cmd_rdy) begin
        issued = 0; xfers = 0; peak = 0;
        req_log.delete(); non_log.delete(); obs_d.delete(); obs_l.delete();
      end
      if (w_cmd_val && w_cmd_rdy) begin w_log.delete(); w_obs.delete(); end
      if (aes_pad_val && aes_pad_rdy) aes_pad_val <= 1'b0;
      if (gen_busy) begin
        if (gen_cnt == 0) begin aes_pad_val <= 1'b1; aes_pad <= pad_fn(gen_ctr); gen_busy = 1'b0; end
        else gen_cnt--;
      end
      if (aes_req_val && aes_req_rdy) begin
        issued++;
        req_log.push_back(aes_counter);
        non_log.push_back(aes_nonce);
        gen_ctr = aes_counter; gen_cnt = gen_lat; gen_busy = 1'b1;
      end
      if (out_val && out_rdy) begin xfers++; obs_d.push_back(out_data); obs_l.push_back(out_last); end
      if (issued - xfers > peak) peak = issued - xfers;
      if (w_pad_val && w_pad_rdy) w_pad_val <= 1'b0;
      if (w_req_val) begin w_log.push_back(w_counter); w_pad_val <= 1'b1; w_pad <= pad_fn(w_counter); end
      if (w_out_val && w_out_rdy) w_obs.push_back(w_out_data);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic sel, input logic [95:0] n);
    int i;
    if (sel) begin w_cmd_val = 1'b1; w_cmd_nonce = n; end else begin cmd_val = 1'b1; cmd_nonce = n; end
    for (i = 0; i < 50; i++) begin @(negedge clk); if (sel ? w_cmd_rdy : cmd_rdy) break; end
    chk("cmd_accept", i < 50, 1);
    @(posedge clk); #1;
    cmd_val = 1'b0; w_cmd_val = 1'b0;
  endtask

  task automatic beat(input logic sel, input logic [127:0] d, input logic l);
    int i;
    if (sel) begin w_in_val = 1'b1; w_in_data = d; w_in_last = l; end else begin in_val = 1'b1; in_data = d; in_last = l; end
    for (i = 0; i < 100; i++) begin @(negedge clk); if (sel ? w_in_rdy : in_rdy) break; end
    chk("beat_accept", i < 100, 1);
    @(posedge clk); #1;
    in_val = 1'b0; w_in_val = 1'b0;
  endtask

  task automatic wait_idle(input logic sel);
    int i;
    for (i = 0; i < 100; i++) begin @(negedge clk); if (!(sel ? w_busy : busy)) break; end
    chk("idle", sel ? w_busy : busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    d4[0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    d4[1] = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
    d4[2] = 128'h0;
    d4[3] = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;
    cmd_val = 0; cmd_nonce = '0; in_val = 0; in_data = '0; in_last = 0; out_rdy = 1; aes_req_rdy = 1;
    w_cmd_val = 0; w_cmd_nonce = '0; w_in_val = 0; w_in_data = '0; w_in_last = 0; w_out_rdy = 1;
    cyc(2);
    rst = 0;
    in_val = 1; #1;
    chk("rst_cmd_rdy", cmd_rdy, 1);
    chk("rst_busy", busy, 0);
    chk("rst_req_val", aes_req_val, 0);
    chk("rst_pad_rdy", aes_pad_rdy, 0);
    chk("rst_out_val", out_val, 0);
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_wrap", ctr_wrap, 0);
    chk("rst_out_data", out_data, 0);
    in_val = 0;
    // single beat
    cmd(0, {12{8'h0A}});
    chk("t1_req_val", aes_req_val, 1);
    chk("t1_req_ctr", aes_counter, 1);
    chk("t1_nonce", aes_nonce, {12{8'h0A}});
    chk("t1_busy", busy, 1);
    beat(0, 128'h0, 1);
    wait_idle(0);
    chk("t1_nout", obs_d.size(), 1);
    chk("t1_out", obs_d[0], 128'hDEADBEEF_00000001_CAFEF00D_FFFFFFFE);
    chk("t1_last", obs_l[0], 1);
    chk("t1_req0", req_log[0], 1);
    chk("t1_cmd_rdy", cmd_rdy, 1);
    // four beats
    gen_lat = 2;
    cmd(0, 96'h123456789ABCDEF012345678);
    for (int k = 0; k < 4; k++) beat(0, d4[k], k == 3);
    wait_idle(0);
    for (int k = 0; k < 4; k++) begin
      chk("t2_out", obs_d[k], d4[k] ^ pad_fn(k + 1));
      chk("t2_ctr", req_log[k], k + 1);
    end
    chk("t2_lastflag", obs_l[3], 1);
    chk("t2_nonce", non_log[3], 96'h123456789ABCDEF012345678);
    chk("t2_peak_le2", peak <= 2, 1);
    chk("t2_reqs_le6", req_log.size() <= 6, 1);
    // backpressure
    gen_lat = 1;
    cmd(0, {12{8'hB5}});
    out_rdy = 0; in_val = 1; in_data = d4[0]; in_last = 0;
    cyc(10);
    chk("t3_in_rdy", in_rdy, 0);
    chk("t3_out_val", out_val, 1);
    chk("t3_inflight", issued - xfers, 2);
    chk("t3_req_val", aes_req_val, 0);
    out_rdy = 1;
    beat(0, d4[0], 0);
    beat(0, d4[3], 1);
    wait_idle(0);
    chk("t3_out0", obs_d[0], d4[0] ^ pad_fn(1));
    chk("t3_out1", obs_d[1], d4[3] ^ pad_fn(2));
    chk("t3_peak", peak, 2);
    // drain with a late pad
    gen_lat = 6;
    cmd(0, {12{8'hC3}});
    beat(0, d4[1], 1);
    chk("t4_busy", busy, 1);
    chk("t4_pad_rdy", aes_pad_rdy, 1);
    chk("t4_issued", issued, 2);
    wait_idle(0);
    chk("t4_out", obs_d[0], d4[1] ^ pad_fn(1));
    gen_lat = 1;
    cmd(0, {12{8'h5E}});
    chk("t4_next_ctr", aes_counter, 1);
    chk("t4_next_nonce", aes_nonce, {12{8'h5E}});
    beat(0, d4[3], 1);
    wait_idle(0);
    chk("t4_next_out", obs_d[0], d4[3] ^ pad_fn(1));
    // reset mid-message with full FIFO
    cmd(0, {12{8'h77}});
    cyc(10);
    chk("t5_full", aes_req_val, 0);
    chk("t5_issued", issued, 2);
    rst = 1; in_val = 1; in_data = d4[0]; in_last = 0;
    cyc(1);
    chk("t5_cmd_rdy", cmd_rdy, 1);
    chk("t5_busy", busy, 0);
    chk("t5_out_val", out_val, 0);
    chk("t5_in_rdy", in_rdy, 0);
    chk("t5_req_val", aes_req_val, 0);
    chk("t5_pad_rdy", aes_pad_rdy, 0);
    rst = 0; in_val = 0;
    cmd(0, {12{8'h99}});
    chk("t5_empty", in_rdy, 0);
    beat(0, d4[0], 1);
    wait_idle(0);
    chk("t5_out", obs_d[0], d4[0] ^ pad_fn(1));
    // counter wrap
    cmd(1, {12{8'h3C}});
    chk("t6_wrap0", w_ctr_wrap, 0);
    chk("t6_ctr0", w_counter, 32'hFFFFFFFF);
    beat(1, d4[0], 0);
    beat(1, d4[3], 1);
    wait_idle(1);
    chk("t6_log0", w_log[0], 32'hFFFFFFFF);
    chk("t6_log1", w_log[1], 32'h0);
    chk("t6_wrap1", w_ctr_wrap, 1);
    chk("t6_out0", w_obs[0], d4[0] ^ pad_fn(32'hFFFFFFFF));
    chk("t6_out1", w_obs[1], d4[3] ^ pad_fn(32'h0));
    cmd(1, {12{8'h42}});
    chk("t6_wrap_clr", w_ctr_wrap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
